// File: rtl/spi_aes_frame_ctrl_pkg.sv
// Shared definitions for the SPI-to-AES frame controller: widths, state
// encodings and word slot helpers (MSW-first word order).
package spi_aes_frame_ctrl_pkg;
    localparam int WORD_W      = 16;
    localparam int WORDS       = 8;
    localparam int BLOCK_W     = 128;
    localparam int AES_TIMEOUT = 64;
    localparam int TMO_W       = $clog2(AES_TIMEOUT + 1);
    localparam int CNT_W       = 3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RX_KEY,
        ST_RX_DATA,
        ST_START,
        ST_WAIT_AES,
        ST_TX
    } state_t;

    // Word k of a 128-bit operand; word 0 is the most significant.
    function automatic logic [WORD_W-1:0] word_of(input logic [BLOCK_W-1:0] v,
                                                  input logic [CNT_W-1:0]   k);
        return WORD_W'(v >> (WORD_W * (WORDS - 1 - int'(k))));
    endfunction

    // Replace word k of a 128-bit operand, leaving the other slots intact.
    function automatic logic [BLOCK_W-1:0] set_word(input logic [BLOCK_W-1:0] v,
                                                    input logic [CNT_W-1:0]   k,
                                                    input logic [WORD_W-1:0]  w);
        int                 sh;
        logic [BLOCK_W-1:0] m;
        sh = WORD_W * (WORDS - 1 - int'(k));
        m  = {{(BLOCK_W-WORD_W){1'b0}}, {WORD_W{1'b1}}} << sh;
        return (v & ~m) | ({{(BLOCK_W-WORD_W){1'b0}}, w} << sh);
    endfunction
endpackage

// File: rtl/spi_aes_frame_ctrl_if.sv
// Bus bundle between the frame controller, the SPI slave and the AES core.
// Names are from the controller's point of view (i_ = into it, o_ = out of it).
interface spi_aes_frame_ctrl_if;
    import spi_aes_frame_ctrl_pkg::*;

    logic               i_cs_n;
    logic [WORD_W-1:0]  i_slv_data_out;
    logic               i_slv_done;
    logic [WORD_W-1:0]  o_slv_data_in;
    logic               o_slv_data_valid;
    logic [BLOCK_W-1:0] o_aes_key;
    logic [BLOCK_W-1:0] o_aes_block;
    logic               o_aes_start;
    logic [BLOCK_W-1:0] i_aes_result;
    logic               i_aes_done;
    logic               o_busy;
    logic               o_frame_err;

    modport slave (
        input  i_cs_n, i_slv_data_out, i_slv_done, i_aes_result, i_aes_done,
        output o_slv_data_in, o_slv_data_valid, o_aes_key, o_aes_block,
               o_aes_start, o_busy, o_frame_err
    );

    modport master (
        output i_cs_n, i_slv_data_out, i_slv_done, i_aes_result, i_aes_done,
        input  o_slv_data_in, o_slv_data_valid, o_aes_key, o_aes_block,
               o_aes_start, o_busy, o_frame_err
    );
endinterface

// File: rtl/spi_aes_frame_ctrl_spi_word_sequencer.sv
// Word-event generator and 3-bit word counter shared by the RX and TX phases.
// The event strobe is one cycle behind the detected slv_done rise so the
// slave's data word has settled before it is captured.
module spi_word_sequencer
    import spi_aes_frame_ctrl_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_slv_done,
    input  logic             i_cnt_clr,
    input  logic             i_cnt_en,
    output logic             o_evt,
    output logic [CNT_W-1:0] o_cnt
);
    logic             r_done_d;
    logic             r_evt;
    logic [CNT_W-1:0] r_cnt;

    // Rising-edge detect on slv_done, registered into a one-cycle strobe.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_done_d <= 1'b0;
            r_evt    <= 1'b0;
        end else begin
            r_done_d <= i_slv_done;
            r_evt    <= i_slv_done & ~r_done_d;
        end
    end

    // Word counter: clear wins; otherwise count only events the FSM accepts.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)                  r_cnt <= '0;
        else if (i_cnt_clr)         r_cnt <= '0;
        else if (r_evt && i_cnt_en) r_cnt <= r_cnt + 1'b1;
    end

    assign o_evt = r_evt;
    assign o_cnt = r_cnt;
endmodule

// File: rtl/spi_aes_frame_ctrl.sv
// Frames SPI slave words into AES operands: 8 key words, 8 plaintext words,
// one start pulse, wait for the core (with timeout), then stream 8 result words.
// A cs_n rise outside IDLE aborts the frame and raises the sticky frame_err.
module spi_aes_frame_ctrl
    import spi_aes_frame_ctrl_pkg::*;
(
    input  logic                  i_clk,
    input  logic                  i_rst,
    spi_aes_frame_ctrl_if.slave   bus
);
    state_t             r_state;
    logic               r_cs_d;
    logic               r_cs_rise;
    logic [BLOCK_W-1:0] r_key;
    logic [BLOCK_W-1:0] r_block;
    logic [BLOCK_W-1:0] r_result;
    logic [WORD_W-1:0]  r_data_in;
    logic               r_valid;
    logic               r_start;
    logic               r_ferr;
    logic [TMO_W-1:0]   r_tmo;

    logic               w_evt;
    logic [CNT_W-1:0]   w_cnt;
    logic               w_abort;
    logic               w_cnt_en;
    logic               w_cnt_clr;
    logic               w_last;

    // cs_n rise is delayed one cycle to line up with the word-event strobe,
    // so a coincident rise and word event land on the same FSM cycle.
    assign w_abort   = r_cs_rise && (r_state != ST_IDLE);
    assign w_cnt_en  = (r_state == ST_RX_KEY) || (r_state == ST_RX_DATA) || (r_state == ST_TX);
    assign w_last    = w_evt && (w_cnt == CNT_W'(WORDS - 1));
    assign w_cnt_clr = w_abort || !w_cnt_en || (w_cnt_en && w_last);

    spi_word_sequencer u_seq (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_slv_done (bus.i_slv_done),
        .i_cnt_clr  (w_cnt_clr),
        .i_cnt_en   (w_cnt_en),
        .o_evt      (w_evt),
        .o_cnt      (w_cnt)
    );

    // Frame FSM with registered outputs; abort takes priority over any word event.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state   <= ST_IDLE;
            r_cs_d    <= 1'b1;
            r_cs_rise <= 1'b0;
            r_key     <= '0;
            r_block   <= '0;
            r_result  <= '0;
            r_data_in <= '0;
            r_valid   <= 1'b0;
            r_start   <= 1'b0;
            r_ferr    <= 1'b0;
            r_tmo     <= '0;
        end else begin
            r_cs_d    <= bus.i_cs_n;
            r_cs_rise <= bus.i_cs_n & ~r_cs_d;
            r_start   <= 1'b0;
            if (w_abort) begin
                r_state   <= ST_IDLE;
                r_ferr    <= 1'b1;
                r_valid   <= 1'b0;
                r_data_in <= '0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        r_valid   <= 1'b0;
                        r_data_in <= '0;
                        if (!bus.i_cs_n) begin
                            r_state <= ST_RX_KEY;
                            r_valid <= 1'b1;
                        end
                    end
                    ST_RX_KEY: begin
                        r_valid   <= 1'b1;
                        r_data_in <= '0;
                        if (w_evt) begin
                            r_key <= set_word(r_key, w_cnt, bus.i_slv_data_out);
                            if (w_cnt == '0) r_ferr  <= 1'b0;
                            if (w_last)      r_state <= ST_RX_DATA;
                        end
                    end
                    ST_RX_DATA: begin
                        r_valid   <= 1'b1;
                        r_data_in <= '0;
                        if (w_evt) begin
                            r_block <= set_word(r_block, w_cnt, bus.i_slv_data_out);
                            if (w_last) begin
                                r_state <= ST_START;
                                r_start <= 1'b1;
                                r_valid <= 1'b0;
                            end
                        end
                    end
                    ST_START: begin
                        r_valid <= 1'b0;
                        r_tmo   <= '0;
                        r_state <= ST_WAIT_AES;
                    end
                    ST_WAIT_AES: begin
                        r_valid <= 1'b0;
                        if (bus.i_aes_done) begin
                            r_result  <= bus.i_aes_result;
                            r_data_in <= word_of(bus.i_aes_result, '0);
                            r_valid   <= 1'b1;
                            r_state   <= ST_TX;
                        end else if (r_tmo == TMO_W'(AES_TIMEOUT - 1)) begin
                            r_ferr  <= 1'b1;
                            r_state <= ST_IDLE;
                        end else begin
                            r_tmo <= r_tmo + 1'b1;
                        end
                    end
                    ST_TX: begin
                        if (w_evt) begin
                            if (w_last) begin
                                r_state   <= ST_IDLE;
                                r_valid   <= 1'b0;
                                r_data_in <= '0;
                            end else begin
                                r_data_in <= word_of(r_result, w_cnt + 1'b1);
                            end
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    assign bus.o_slv_data_in    = r_data_in;
    assign bus.o_slv_data_valid = r_valid;
    assign bus.o_aes_key        = r_key;
    assign bus.o_aes_block      = r_block;
    assign bus.o_aes_start      = r_start;
    assign bus.o_busy           = (r_state != ST_IDLE);
    assign bus.o_frame_err      = r_ferr;
endmodule

// File: tb/tb_spi_aes_frame_ctrl.sv
// Self-checking bench for spi_aes_frame_ctrl: table of full frames plus
// hand-written reset, abort, timeout, spurious-event and coincident-abort cases.
// TX words are checked through a scoreboard queue filled when aes_done is driven.
module tb_spi_aes_frame_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    spi_aes_frame_ctrl_if bus ();
    spi_aes_frame_ctrl dut (.i_clk(clk), .i_rst(rst), .bus(bus.slave));

    typedef struct {
        logic [127:0] key;
        logic [127:0] pt;
        logic [127:0] res;
    } vec_t;
    vec_t tv [3];

    int n_vec = 0;
    int n_err = 0;
    int n_start = 0;
    logic st1, st2;
    logic [15:0] exp_q [$];

    always @(posedge clk) if (bus.o_aes_start) n_start <= n_start + 1;

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // One SPI word: done rises with the data; cs_mode 1 raises cs_n together
    // with done, 2 raises it one cycle later.
    task automatic send_word(input logic [15:0] w, input int cs_mode);
        @(negedge clk);
        bus.i_slv_data_out = w;
        bus.i_slv_done     = 1'b1;
        if (cs_mode == 1) bus.i_cs_n = 1'b1;
        @(negedge clk);
        st1 = bus.o_aes_start;
        if (cs_mode == 2) bus.i_cs_n = 1'b1;
        @(negedge clk);
        st2 = bus.o_aes_start;
        bus.i_slv_done = 1'b0;
        @(negedge clk);
    endtask

    task automatic send_words(input logic [127:0] v, input int first, input int n);
        logic [15:0] w;
        for (int k = first; k < first + n; k++) begin
            w = 16'(v >> (16 * (7 - k)));
            send_word(w, 0);
        end
    endtask

    task automatic start_frame();
        @(negedge clk);
        bus.i_cs_n = 1'b0;
        @(negedge clk);
    endtask

    // Answer the AES start, then read the 8 result words back.
    task automatic finish_tx(input logic [127:0] res, input int last_mode);
        logic [15:0] w;
        for (int k = 0; k < 8; k++) exp_q.push_back(16'(res >> (16 * (7 - k))));
        @(negedge clk);
        check("valid in WAIT_AES", bus.o_slv_data_valid, 1'b0);
        bus.i_aes_result = res;
        bus.i_aes_done   = 1'b1;
        @(negedge clk);
        bus.i_aes_done   = 1'b0;
        for (int k = 0; k < 8; k++) begin
            w = exp_q.pop_front();
            check($sformatf("tx valid w%0d", k), bus.o_slv_data_valid, 1'b1);
            check($sformatf("tx word w%0d", k), bus.o_slv_data_in, w);
            send_word(16'hdead, (k == 7) ? last_mode : 0);
        end
    endtask

    initial begin
        int s0, i, bad;
        tv[0] = '{128'h000102030405060708090a0b0c0d0e0f, 128'h00112233445566778899aabbccddeeff,
                  128'h69c4e0d86a7b0430d8cdb78070b4c55a};
        tv[1] = '{128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h3243f6a8885a308d313198a2e0370734,
                  128'h3925841d02dc09fbdc118597196a0b32};
        tv[2] = '{128'hffffeeeeddddccccbbbbaaaa99998888, 128'h0123456789abcdeffedcba9876543210,
                  128'ha5a55a5a0f0ff0f01234567890abcdef};
        bus.i_cs_n = 1'b1; bus.i_slv_data_out = '0; bus.i_slv_done = 1'b0;
        bus.i_aes_result = '0; bus.i_aes_done = 1'b0;
        repeat (3) @(negedge clk);
        check("rst busy", bus.o_busy, 1'b0);
        check("rst frame_err", bus.o_frame_err, 1'b0);
        check("rst valid", bus.o_slv_data_valid, 1'b0);
        check("rst data_in", bus.o_slv_data_in, 16'h0);
        check("rst key", bus.o_aes_key, 128'h0);
        check("rst block", bus.o_aes_block, 128'h0);
        check("rst start", bus.o_aes_start, 1'b0);
        rst = 1'b0;

        // Table of full frames.
        for (int v = 0; v < 3; v++) begin
            s0 = n_start;
            start_frame();
            check("rx valid", bus.o_slv_data_valid, 1'b1);
            check("rx data_in", bus.o_slv_data_in, 16'h0);
            send_words(tv[v].key, 0, 8);
            send_words(tv[v].pt, 0, 8);
            check("start latency +1", st1, 1'b0);
            check("start latency +2", st2, 1'b1);
            check("aes_key", bus.o_aes_key, tv[v].key);
            check("aes_block", bus.o_aes_block, tv[v].pt);
            check("start pulses", n_start - s0, 1);
            finish_tx(tv[v].res, 2);
            check("end busy", bus.o_busy, 1'b0);
            check("end frame_err", bus.o_frame_err, 1'b0);
        end

        // Reset after 3 plaintext words; next frame restarts at word 0.
        s0 = n_start;
        start_frame();
        send_words(tv[0].key, 0, 8);
        send_words(tv[0].pt, 0, 3);
        @(negedge clk); rst = 1'b1; bus.i_cs_n = 1'b1;
        @(negedge clk);
        check("mid-rst busy", bus.o_busy, 1'b0);
        check("mid-rst frame_err", bus.o_frame_err, 1'b0);
        check("mid-rst key", bus.o_aes_key, 128'h0);
        @(negedge clk); rst = 1'b0;
        repeat (2) @(negedge clk);
        check("mid-rst no start", n_start - s0, 0);
        start_frame();
        send_words(tv[1].key, 0, 8);
        send_words(tv[1].pt, 0, 8);
        check("post-rst key", bus.o_aes_key, tv[1].key);
        check("post-rst block", bus.o_aes_block, tv[1].pt);
        finish_tx(tv[1].res, 2);

        // cs_n abort after 5 key words; partial key kept; next first word clears error.
        s0 = n_start;
        start_frame();
        send_words(tv[2].key, 0, 5);
        @(negedge clk); bus.i_cs_n = 1'b1;
        repeat (3) @(negedge clk);
        check("abort frame_err", bus.o_frame_err, 1'b1);
        check("abort busy", bus.o_busy, 1'b0);
        check("abort no start", n_start - s0, 0);
        check("abort partial key", bus.o_aes_key, {tv[2].key[127:48], tv[1].key[47:0]});
        start_frame();
        check("err held to 1st word", bus.o_frame_err, 1'b1);
        send_word(16'h1234, 0);
        check("err cleared", bus.o_frame_err, 1'b0);
        @(negedge clk); bus.i_cs_n = 1'b1;
        repeat (3) @(negedge clk);

        // Spurious aes_done in RX_KEY and word events in WAIT_AES.
        s0 = n_start;
        start_frame();
        send_words(tv[0].key, 0, 3);
        @(negedge clk); bus.i_aes_result = tv[2].res; bus.i_aes_done = 1'b1;
        @(negedge clk); bus.i_aes_done = 1'b0;
        check("spur done busy", bus.o_busy, 1'b1);
        send_words(tv[0].key, 3, 5);
        send_words(tv[0].pt, 0, 8);
        check("spur key", bus.o_aes_key, tv[0].key);
        send_word(16'hbeef, 0);
        send_word(16'hcafe, 0);
        check("spur words busy", bus.o_busy, 1'b1);
        check("spur block", bus.o_aes_block, tv[0].pt);
        finish_tx(tv[0].res, 2);
        check("spur start pulses", n_start - s0, 1);
        check("spur end busy", bus.o_busy, 1'b0);

        // AES never answers: 64 cycles in WAIT_AES then abort.
        start_frame();
        send_words(tv[2].key, 0, 8);
        send_words(tv[2].pt, 0, 8);
        bad = 0;
        for (i = 1; i <= 80; i++) begin
            @(negedge clk);
            if (bus.o_slv_data_valid !== 1'b0) bad++;
            if (!bus.o_busy) break;
        end
        check("timeout cycles", i, 64);
        check("timeout valid low", bad, 0);
        check("timeout frame_err", bus.o_frame_err, 1'b1);
        @(negedge clk); bus.i_cs_n = 1'b1;
        repeat (3) @(negedge clk);

        // cs_n rise coincident with the 8th TX word event: abort wins.
        start_frame();
        send_words(tv[1].key, 0, 8);
        send_words(tv[1].pt, 0, 8);
        finish_tx(tv[1].res, 1);
        check("coinc frame_err", bus.o_frame_err, 1'b1);
        check("coinc busy", bus.o_busy, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end
endmodule
